// File: rtl/qsys1_pio_master_if.sv
// Command/response and Avalon-MM signal bundle for qsys1_pio_master.
// The master modport is the initiator's view. The slave modport is the view of the local controller and the Avalon slave.
interface qsys1_pio_master_if #(parameter int ADDR_W = 2);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       cmd_writedata;
  logic              rsp_valid;
  logic [31:0]       rsp_readdata;
  logic              rsp_timeout;
  logic              avm_chipselect;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_timeout,
           avm_chipselect, avm_address, avm_write_n, avm_read_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_timeout,
           avm_chipselect, avm_address, avm_write_n, avm_read_n, avm_writedata
  );
endinterface

// File: rtl/qsys1_pio_master.sv
// Avalon-MM single-word initiator. It accepts one command, runs the bus transfer with a waitrequest timeout, and returns one response pulse.
module qsys1_pio_master #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  qsys1_pio_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              cs_q, cs_d;
  logic              write_n_q, write_n_d;
  logic              read_n_q, read_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              tmo_q, tmo_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    cs_d        = cs_q;
    write_n_d   = write_n_q;
    read_n_d    = read_n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        state_d   = BUS;
        wr_d      = bus.cmd_write;
        addr_d    = bus.cmd_address;
        wdata_d   = bus.cmd_writedata;
        cs_d      = 1'b1;
        write_n_d = ~bus.cmd_write;
        read_n_d  = bus.cmd_write;
        cnt_d     = '0;
      end
      BUS: begin
        if (!bus.avm_waitrequest || cnt_q == 16'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b0;
          write_n_d   = 1'b1;
          read_n_d    = 1'b1;
          // A stalled final cycle means the count is exhausted and this is a timeout.
          tmo_d       = bus.avm_waitrequest;
          rdata_d     = (bus.avm_waitrequest || wr_q) ? 32'h0 : bus.avm_readdata;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_readdata   = rdata_q;
  assign bus.rsp_timeout    = tmo_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_read_n     = read_n_q;
  assign bus.avm_writedata  = wdata_q;
endmodule
